// File: rtl/fpu_pipe_issuer.sv
// Requester-side front end for a fixed-latency, free-running FPU (fdiv): issue, in-flight tracking, in-order skid FIFO.
// Optional perf counters are built only when FPU_ISSUE_PERF_EN is defined.
module fpu_pipe_issuer #(
    parameter int LAT   = 6,
    parameter int TAGW  = 5,
    parameter int DEPTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [31:0]     i_req_x1,
    input  logic [31:0]     i_req_x2,
    input  logic [TAGW-1:0] i_req_tag,
    output logic [31:0]     o_fu_x1,
    output logic [31:0]     o_fu_x2,
    input  logic [31:0]     i_fu_y,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [31:0]     o_resp_y,
    output logic [TAGW-1:0] o_resp_tag,
    output logic            o_busy,
    output logic [31:0]     o_perf_issued,
    output logic [31:0]     o_perf_stall
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_fill;
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [31:0]     r_fuX1;
    logic [31:0]     r_fuX2;
    logic [LAT:0]    r_stValid;
    logic [TAGW-1:0] r_stTag  [0:LAT];
    logic [31:0]     r_memY   [0:DEPTH-1];
    logic [TAGW-1:0] r_memTag [0:DEPTH-1];

    logic w_accept;
    logic w_pop;
    logic w_fifoWrite;
    logic w_full;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop in the same cycle frees its credit, so a full window can still accept.
    assign o_req_ready  = ~i_rst & ((r_count < CW'(DEPTH)) | w_pop);
    assign w_accept     = i_req_valid & o_req_ready;
    assign w_pop        = o_resp_valid & i_resp_ready;
    assign w_fifoWrite  = r_stValid[LAT];
    assign w_full       = (r_fill == CW'(DEPTH));

    assign o_fu_x1      = r_fuX1;
    assign o_fu_x2      = r_fuX2;
    assign o_resp_valid = (r_fill != '0);
    assign o_resp_y     = r_memY[r_rdPtr];
    assign o_resp_tag   = r_memTag[r_rdPtr];
    assign o_busy       = (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fuX1    <= '0;
            r_fuX2    <= '0;
            r_stValid <= '0;
        end else begin
            r_stValid <= {r_stValid[LAT-1:0], w_accept};
            if (w_accept) begin
                r_fuX1 <= i_req_x1;
                r_fuX2 <= i_req_x2;
            end
        end
    end

    // Tags ride alongside the valid bits; their value only matters where valid is set.
    always_ff @(posedge i_clk) begin
        r_stTag[0] <= i_req_tag;
        for (int k = 1; k <= LAT; k++) begin
            r_stTag[k] <= r_stTag[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_fifoWrite) begin
            r_memY[r_wrPtr]   <= i_fu_y;
            r_memTag[r_wrPtr] <= r_stTag[LAT];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_fill  <= '0;
            r_count <= '0;
        end else begin
            if (w_fifoWrite) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_fifoWrite, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The credit window bounds FIFO occupancy, so a write into a full FIFO means the credit logic is broken.
    assert property (@(posedge i_clk) disable iff (i_rst) !(w_fifoWrite && w_full));

`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] r_perfIssued;
    logic [31:0] r_perfStall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perfIssued <= '0;
            r_perfStall  <= '0;
        end else begin
            if (w_accept) begin
                r_perfIssued <= r_perfIssued + 32'd1;
            end
            if (i_req_valid & ~o_req_ready) begin
                r_perfStall <= r_perfStall + 32'd1;
            end
        end
    end

    assign o_perf_issued = r_perfIssued;
    assign o_perf_stall  = r_perfStall;
`else
    assign o_perf_issued = '0;
    assign o_perf_stall  = '0;
`endif

endmodule

// File: tb/tb_fpu_pipe_issuer.sv
// Directed bench for fpu_pipe_issuer with a 6-cycle stand-in divider on the FPU port.
// Expects perf counter values according to whether FPU_ISSUE_PERF_EN is defined.
module tb_fpu_pipe_issuer;
    localparam int LAT   = 6;
    localparam int TAGW  = 5;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            reqValid;
    logic            reqReady;
    logic [31:0]     reqX1;
    logic [31:0]     reqX2;
    logic [TAGW-1:0] reqTag;
    logic [31:0]     fuX1;
    logic [31:0]     fuX2;
    logic [31:0]     fuY;
    logic            respValid;
    logic            respReady;
    logic [31:0]     respY;
    logic [TAGW-1:0] respTag;
    logic            busy;
    logic [31:0]     perfIssued;
    logic [31:0]     perfStall;

    int checks   = 0;
    int failures = 0;

    logic [31:0] fpuPipe [0:LAT-1];
    logic        sawValid;

    fpu_pipe_issuer #(.LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (reqValid),
        .o_req_ready   (reqReady),
        .i_req_x1      (reqX1),
        .i_req_x2      (reqX2),
        .i_req_tag     (reqTag),
        .o_fu_x1       (fuX1),
        .o_fu_x2       (fuX2),
        .i_fu_y        (fuY),
        .o_resp_valid  (respValid),
        .i_resp_ready  (respReady),
        .o_resp_y      (respY),
        .o_resp_tag    (respTag),
        .o_busy        (busy),
        .o_perf_issued (perfIssued),
        .o_perf_stall  (perfStall)
    );

    always #5 clk = ~clk;

    // Quotients for the operand pairs used below; x/1.0 passes x through unchanged.
    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h3F800000) return a;
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
        if (a == 32'h41100000 && b == 32'h40400000) return 32'h40400000;
        return 32'h7FC00000;
    endfunction

    always @(posedge clk) begin
        fpuPipe[0] <= fdiv(fuX1, fuX2);
        for (int k = 1; k < LAT; k++) begin
            fpuPipe[k] <= fpuPipe[k-1];
        end
    end
    assign fuY = fpuPipe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] x1, input logic [31:0] x2,
                                 input logic [TAGW-1:0] t, input logic rr);
        reqValid  = v;
        reqX1     = x1;
        reqX2     = x2;
        reqTag    = t;
        respReady = rr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", name, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        tick();
        checkOutput("rst_req_ready", 32'(reqReady), 32'd0);
        checkOutput("rst_resp_valid", 32'(respValid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_fu_x1", fuX1, 32'd0);
        checkOutput("rst_fu_x2", fuX2, 32'd0);
        checkOutput("rst_perf_issued", perfIssued, 32'd0);
        checkOutput("rst_perf_stall", perfStall, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("idle_req_ready", 32'(reqReady), 32'd1);

        $display("[TB] single op 6.0/2.0");
        applyStimulus(1'b1, 32'h40C00000, 32'h40000000, 5'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b1);
        checkOutput("single_fu_x1", fuX1, 32'h40C00000);
        checkOutput("single_fu_x2", fuX2, 32'h40000000);
        checkOutput("single_busy_inflight", 32'(busy), 32'd1);
        repeat (6) tick();
        checkOutput("single_valid_c7", 32'(respValid), 32'd0);
        tick();
        checkOutput("single_valid_c8", 32'(respValid), 32'd1);
        checkOutput("single_y", respY, 32'h40400000);
        checkOutput("single_tag", 32'(respTag), 32'd3);
        checkOutput("single_busy_c8", 32'(busy), 32'd1);
        tick();
        checkOutput("single_valid_c9", 32'(respValid), 32'd0);
        checkOutput("single_busy_c9", 32'(busy), 32'd0);
        checkOutput("single_fu_x1_hold", fuX1, 32'h40C00000);

        $display("[TB] streaming 16 ops");
        for (int k = 0; k < 24; k++) begin
            if (k < 16) begin
                applyStimulus(1'b1, 32'h41000000 + (32'(k) << 16), 32'h3F800000, 5'(k), 1'b1);
                checkOutput("stream_req_ready", 32'(reqReady), 32'd1);
            end else begin
                applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b1);
            end
            if (k >= 8) begin
                checkOutput("stream_valid", 32'(respValid), 32'd1);
                checkOutput("stream_tag", 32'(respTag), 32'(k - 8));
                checkOutput("stream_y", respY, 32'h41000000 + (32'(k - 8) << 16));
            end else begin
                checkOutput("stream_early_valid", 32'(respValid), 32'd0);
            end
            tick();
        end
        checkOutput("stream_end_valid", 32'(respValid), 32'd0);
        checkOutput("stream_end_busy", 32'(busy), 32'd0);

        $display("[TB] backpressure, stall counting, accept with pop at full credit");
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 13; k++) begin
            applyStimulus(1'b1, 32'h40000000 + (32'(k) << 20), 32'h3F800000, 5'(k), 1'b0);
            checkOutput("bp_req_ready", 32'(reqReady), 32'(k < 8));
            if (k >= 8) begin
                checkOutput("bp_held_valid", 32'(respValid), 32'd1);
                checkOutput("bp_held_tag", 32'(respTag), 32'd0);
                checkOutput("bp_held_y", respY, 32'h40000000);
            end
            tick();
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
`ifdef FPU_ISSUE_PERF_EN
        checkOutput("perf_issued", perfIssued, 32'd8);
        checkOutput("perf_stall", perfStall, 32'd5);
`else
        checkOutput("perf_issued_off", perfIssued, 32'd0);
        checkOutput("perf_stall_off", perfStall, 32'd0);
`endif
        checkOutput("bp_busy", 32'(busy), 32'd1);
        checkOutput("bp_ready_low", 32'(reqReady), 32'd0);
        repeat (3) tick();
        applyStimulus(1'b1, 32'h3F800000, 32'h40800000, 5'd9, 1'b1);
        checkOutput("full_accept_with_pop", 32'(reqReady), 32'd1);
        checkOutput("full_head_tag", 32'(respTag), 32'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        checkOutput("full_count_still_8", 32'(reqReady), 32'd0);
        checkOutput("full_next_tag", 32'(respTag), 32'd1);
        checkOutput("full_fu_x1", fuX1, 32'h3F800000);
        checkOutput("full_fu_x2", fuX2, 32'h40800000);
        tick();
        for (int k = 1; k < 8; k++) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b1);
            checkOutput("drain_valid", 32'(respValid), 32'd1);
            checkOutput("drain_tag", 32'(respTag), 32'(k));
            checkOutput("drain_y", respY, 32'h40000000 + (32'(k) << 20));
            tick();
        end
        checkOutput("quarter_valid", 32'(respValid), 32'd1);
        checkOutput("quarter_tag", 32'(respTag), 32'd9);
        checkOutput("quarter_y", respY, 32'h3E800000);
        tick();
        checkOutput("drained_valid", 32'(respValid), 32'd0);
        checkOutput("drained_busy", 32'(busy), 32'd0);
        checkOutput("drained_req_ready", 32'(reqReady), 32'd1);

        $display("[TB] reset with ops in flight");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h41000000 + (32'(k) << 16), 32'h3F800000, 5'(20 + k), 1'b1);
            tick();
        end
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b1);
        checkOutput("midrst_req_ready", 32'(reqReady), 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 32'h41100000, 32'h40400000, 5'd17, 1'b1);
        checkOutput("postrst_req_ready", 32'(reqReady), 32'd1);
        checkOutput("postrst_busy", 32'(busy), 32'd0);
        checkOutput("postrst_valid", 32'(respValid), 32'd0);
        checkOutput("postrst_fu_x1", fuX1, 32'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b1);
        sawValid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (respValid) sawValid = 1'b1;
            tick();
        end
        checkOutput("postrst_no_stale_resp", 32'(sawValid), 32'd0);
        checkOutput("postrst_new_valid", 32'(respValid), 32'd1);
        checkOutput("postrst_new_tag", 32'(respTag), 32'd17);
        checkOutput("postrst_new_y", respY, 32'h40400000);
        tick();
        checkOutput("postrst_final_busy", 32'(busy), 32'd0);
        checkOutput("postrst_final_valid", 32'(respValid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
